axi_ram_responder: RTL and testbench



---
 rtl/axi_ram_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi_ram_responder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_responder.sv
// -----------------------------------------------------------------------------
// axi_ram_responder
//
// AXI4 slave endpoint backed by an internal synchronous RAM. Write and read
// channels are served by two independent FSMs. Each FSM has exactly one
// transaction outstanding. IDs are echoed back unchanged and responses are
// always OKAY.
//
// Ports
//   clk, rst            sole clock (rising edge); asynchronous active-low reset
//   s_axi_aw*           write address channel (id, addr, len, size, burst)
//   s_axi_w*            write data channel (data, strobes, wlast is ignored)
//   s_axi_b*            write response channel
//   s_axi_ar*           read address channel
//   s_axi_r*            read data channel
// -----------------------------------------------------------------------------
module axi_ram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,

  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,

  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,

  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,

  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int         OFFS     = $clog2(STRB_WIDTH);
  localparam int         WORDS    = 2 ** (ADDR_WIDTH - OFFS);
  localparam logic [2:0] MAX_SIZE = 3'(OFFS);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'b00;

  // FIXED holds the address; INCR, WRAP and the reserved code all step by the
  // beat size and roll over at the top of the address space.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    if (burst == BURST_FIXED) return addr;
    return addr + (ADDR_WIDTH'(1) << size);
  endfunction

  // Beats wider than the bus are narrowed to the bus width.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > MAX_SIZE) ? MAX_SIZE : size;
  endfunction

  function automatic logic [ADDR_WIDTH-OFFS-1:0] word_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:OFFS];
  endfunction

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // wlast carries no information here; the beat count comes from awlen alone.
  logic unused;
  assign unused = s_axi_wlast;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic [1:0]            w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [7:0]            w_cnt;
  logic                  w_fire;

  assign w_fire = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;

  // NOTE: every register in a clocked block is updated with <= so all of them
  // sample the pre-edge values; blocking here would create ordering bugs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state       <= W_IDLE;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_cnt         <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            w_id          <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= clamp_size(s_axi_awsize);
            w_burst       <= s_axi_awburst;
            w_cnt         <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            // Rises one edge after reset release; stays high while idle.
            s_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= next_addr(w_addr, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            if (w_cnt == w_len) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              s_axi_bresp  <= 2'b00;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: begin
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b0;
          s_axi_bvalid  <= 1'b0;
          w_state       <= W_IDLE;
        end
      endcase
    end
  end

  // NOTE: the RAM array has no reset; clearing it would turn the memory into
  // a large flop bank. Beats already written before a reset stay in place.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem[word_of(w_addr)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [7:0]            r_cnt;
  logic [7:0]            r_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_nxt;

  assign r_cnt_nxt  = r_cnt + 8'd1;
  assign r_addr_nxt = next_addr(r_addr, r_size, r_burst);

  // rdata is loaded on the AR handshake and on every non-last R handshake, so
  // the next beat is ready on the following cycle with no bubble. A write on
  // the same edge lands after this read, so the old word is returned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= R_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_cnt         <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_size        <= clamp_size(s_axi_arsize);
            r_burst       <= s_axi_arburst;
            r_cnt         <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rid     <= s_axi_arid;
            s_axi_rresp   <= 2'b00;
            s_axi_rdata   <= mem[word_of(s_axi_araddr)];
            r_state       <= R_DATA;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_cnt       <= r_cnt_nxt;
              r_addr      <= r_addr_nxt;
              s_axi_rlast <= (r_cnt_nxt == r_len);
              s_axi_rdata <= mem[word_of(r_addr_nxt)];
            end
          end
        end
        default: begin
          s_axi_arready <= 1'b0;
          s_axi_rvalid  <= 1'b0;
          s_axi_rlast   <= 1'b0;
          r_state       <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_ram_responder
//
// Directed bench for axi_ram_responder. Stimulus tasks push the expected B and
// R responses into queues; a monitor pops and compares them on every
// handshake it observes. Timing and stability checks sit in the main flow.
// -----------------------------------------------------------------------------
module tb_axi_ram_responder;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic        last;
  } r_beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [7:0]  awid = '0;
  logic [15:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  arid = '0;
  logic [15:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  r_beat_t    r_exp[$];
  logic [7:0] b_exp[$];

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  axi_ram_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs change only just after posedge, so valid&ready seen at
  // negedge is exactly the handshake taken at the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      if (rvalid && rready) begin
        check("r_expected_beat", r_exp.size() != 0, 1'b1);
        if (r_exp.size() != 0) begin
          r_beat_t e;
          e = r_exp.pop_front();
          check("rdata", rdata, e.data);
          check("rid", rid, e.id);
          check("rlast", rlast, e.last);
          check("rresp", rresp, 2'b00);
        end
      end
      if (bvalid && bready) begin
        check("b_expected_resp", b_exp.size() != 0, 1'b1);
        if (b_exp.size() != 0) begin
          logic [7:0] e;
          e = b_exp.pop_front();
          check("bid", bid, e);
          check("bresp", bresp, 2'b00);
        end
      end
    end
  end

  task automatic expect_r(input logic [7:0] id, input logic [31:0] data, input logic last);
    r_beat_t e;
    e.id = id; e.data = data; e.last = last;
    r_exp.push_back(e);
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [15:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    bit seen = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (awready) seen = 1'b1;
    end
    check("aw_handshake", seen, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    bit seen = 1'b0;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (wready) seen = 1'b1;
    end
    check("w_handshake", seen, 1'b1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [15:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    bit seen = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (arready) seen = 1'b1;
    end
    check("ar_handshake", seen, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_r_done();
    for (int i = 0; i < 100 && r_exp.size() != 0; i++) @(negedge clk);
    check("r_drain", r_exp.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_b_done();
    for (int i = 0; i < 100 && b_exp.size() != 0; i++) @(negedge clk);
    check("b_drain", b_exp.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:0] pat [5];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bid_rid", {bid, rid, bresp, rresp}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("awready_before_first_edge", awready, 0);
    @(posedge clk); #1;
    check("awready_after_release", awready, 1);
    check("arready_after_release", arready, 1);
    bready = 1'b1;
    rready = 1'b1;

    // Single write and readback
    b_exp.push_back(8'h5A);
    send_aw(8'h5A, 16'h0010, 8'd0, INCR);
    check("wready_after_aw", wready, 1);
    check("awready_after_aw", awready, 0);
    send_w(32'hDEADBEEF, 4'hF);
    check("bvalid_after_last_w", bvalid, 1);
    check("wready_after_last_w", wready, 0);
    wait_b_done();
    expect_r(8'h33, 32'hDEADBEEF, 1'b1);
    send_ar(8'h33, 16'h0010, 8'd0, INCR);
    check("rvalid_after_ar", rvalid, 1);
    wait_r_done();

    // INCR burst, back-to-back read beats
    b_exp.push_back(8'h21);
    send_aw(8'h21, 16'h0100, 8'd3, INCR);
    send_w(32'h11111111, 4'hF);
    send_w(32'h22222222, 4'hF);
    send_w(32'h33333333, 4'hF);
    send_w(32'h44444444, 4'hF);
    wait_b_done();
    expect_r(8'h22, 32'h11111111, 1'b0);
    expect_r(8'h22, 32'h22222222, 1'b0);
    expect_r(8'h22, 32'h33333333, 1'b0);
    expect_r(8'h22, 32'h44444444, 1'b1);
    send_ar(8'h22, 16'h0100, 8'd3, INCR);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("incr_rvalid_back_to_back", rvalid, 1);
      check("incr_rlast_position", rlast, (i == 3));
    end
    @(negedge clk);
    check("incr_rvalid_done", rvalid, 0);
    check("incr_arready_back", arready, 1);
    wait_r_done();

    // Strobes and FIXED burst
    b_exp.push_back(8'h01);
    send_aw(8'h01, 16'h0200, 8'd0, INCR);
    send_w(32'hFFFFFFFF, 4'hF);
    wait_b_done();
    b_exp.push_back(8'h02);
    send_aw(8'h02, 16'h0200, 8'd1, FIXED);
    send_w(32'h000000AA, 4'h1);
    send_w(32'h00BB0000, 4'h4);
    wait_b_done();
    expect_r(8'h03, 32'hFFBBFFAA, 1'b1);
    send_ar(8'h03, 16'h0200, 8'd0, INCR);
    wait_r_done();

    // Read backpressure: rready 1,0,0,1,1 over a three-beat burst
    rready = 1'b0;
    expect_r(8'h44, 32'h11111111, 1'b0);
    expect_r(8'h44, 32'h22222222, 1'b0);
    expect_r(8'h44, 32'h33333333, 1'b1);
    send_ar(8'h44, 16'h0100, 8'd2, INCR);
    for (int i = 0; i < 5; i++) begin
      rready = pat[i][0];
      @(negedge clk);
      if (!pat[i][0]) begin
        check("stall_rvalid", rvalid, 1);
        check("stall_rdata", rdata, 32'h22222222);
        check("stall_rlast", rlast, 0);
        check("stall_rid", rid, 8'h44);
      end
      @(posedge clk); #1;
    end
    check("stall_burst_done", rvalid, 0);
    check("stall_beats_accepted", r_exp.size(), 0);
    rready = 1'b1;

    // Write response backpressure
    bready = 1'b0;
    b_exp.push_back(8'h77);
    send_aw(8'h77, 16'h0300, 8'd0, INCR);
    send_w(32'h12345678, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bstall_bvalid", bvalid, 1);
      check("bstall_awready", awready, 0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    wait_b_done();
    check("awready_after_b", awready, 1);

    // Address wrap at the top of the space
    b_exp.push_back(8'h0F);
    send_aw(8'h0F, 16'hFFFC, 8'd1, INCR);
    send_w(32'hCAFEF00D, 4'hF);
    send_w(32'h0BADC0DE, 4'hF);
    wait_b_done();
    expect_r(8'h10, 32'h0BADC0DE, 1'b1);
    send_ar(8'h10, 16'h0000, 8'd0, INCR);
    wait_r_done();
    expect_r(8'h11, 32'hCAFEF00D, 1'b0);
    expect_r(8'h11, 32'h0BADC0DE, 1'b1);
    send_ar(8'h11, 16'hFFFC, 8'd1, INCR);
    wait_r_done();

    // Reset in the middle of a len-7 write burst (no response expected)
    send_aw(8'h99, 16'h0400, 8'd7, INCR);
    send_w(32'h000000A0, 4'hF);
    send_w(32'h000000A1, 4'hF);
    wdata = 32'h000000A2; wstrb = 4'hF; wvalid = 1'b1;
    rst = 1'b0;
    #1;
    check("midrst_wready", wready, 0);
    check("midrst_awready", awready, 0);
    check("midrst_bvalid", bvalid, 0);
    check("midrst_arready", arready, 0);
    check("midrst_rvalid", rvalid, 0);
    wvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_awready_low", awready, 0);
    @(posedge clk); #1;
    check("midrst_awready_back", awready, 1);
    expect_r(8'h55, 32'h000000A0, 1'b0);
    expect_r(8'h55, 32'h000000A1, 1'b1);
    send_ar(8'h55, 16'h0400, 8'd1, INCR);
    wait_r_done();
    b_exp.push_back(8'h42);
    send_aw(8'h42, 16'h0500, 8'd1, INCR);
    send_w(32'h5555AAAA, 4'hF);
    send_w(32'h6666BBBB, 4'hF);
    wait_b_done();
    expect_r(8'h43, 32'h5555AAAA, 1'b0);
    expect_r(8'h43, 32'h6666BBBB, 1'b1);
    send_ar(8'h43, 16'h0500, 8'd1, INCR);
    wait_r_done();

    repeat (5) @(posedge clk);
    check("final_r_queue_empty", r_exp.size(), 0);
    check("final_b_queue_empty", b_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
